// File: rtl/addr_latch_incdec_if.sv
`default_nettype none
// ============================================================================
//  Module      : addr_latch_incdec_if
//  Description : Control / status bundle of the address latch with
//                incrementer/decrementer. The master drives the control
//                strobes; the slave (the latch) returns its status flags.
//                The bidirectional data buses and the tri-state address pins
//                stay plain ports on the latch itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface addr_latch_incdec_if;

    // Control strobes, sampled on the rising clock edge
    logic ctl_al_we;        // latch {db_hi_as,db_lo_as} into AL
    logic ctl_inc_cy;       // step amount: 0 = pass-through, 1 = step by one
    logic ctl_inc_dec;      // 0 = increment, 1 = decrement
    logic ctl_inc_limit7;   // step only the low 7 bits (refresh counter mode)
    logic ctl_al_out;       // drive RES onto the data buses
    logic ctl_bus_oe;       // request external address drive

    // Status returned by the latch
    logic abus_oe;          // registered copy of ctl_bus_oe
    logic res_pend;         // RES not yet refreshed from the current AL
    logic address_is_1;     // registered AL == 16'h0001 flag

    modport master (
        output ctl_al_we,
        output ctl_inc_cy,
        output ctl_inc_dec,
        output ctl_inc_limit7,
        output ctl_al_out,
        output ctl_bus_oe,
        input  abus_oe,
        input  res_pend,
        input  address_is_1
    );

    modport slave (
        input  ctl_al_we,
        input  ctl_inc_cy,
        input  ctl_inc_dec,
        input  ctl_inc_limit7,
        input  ctl_al_out,
        input  ctl_bus_oe,
        output abus_oe,
        output res_pend,
        output address_is_1
    );

endinterface : addr_latch_incdec_if
`default_nettype wire

// File: rtl/addr_latch_incdec.sv
`default_nettype none
// ============================================================================
//  Module      : addr_latch_incdec
//  Description : 16-bit address latch (AL) feeding an incrementer/decrementer
//                whose result is held in RES one edge after each latch. RES
//                can be driven back onto the address-side data buses, and AL
//                can be driven out on the tri-state address pins.
//                Optional feature macro: ADDR_ZERO_DETECT_EN -- when defined,
//                a registered AL == 16'h0001 flag is built; when undefined the
//                flag output is tied low and no comparator/flop exists.
//  Revision    : 1.0  initial release
// ============================================================================
module addr_latch_incdec (
    input  wire logic                 clk,
    input  wire logic                 nreset,
    addr_latch_incdec_if.slave        ctl_if,
    inout  wire       [7:0]           db_lo_as,
    inout  wire       [7:0]           db_hi_as,
    output wire       [15:0]          address
);

    localparam logic [15:0] c_ADDR_ONE = 16'h0001;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:0] al_q,       al_d;
    logic [15:0] res_q,      res_d;
    logic        res_pend_q, res_pend_d;
    logic        abus_oe_q,  abus_oe_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [15:0] w_bus_in;      // resolved value on the data buses
    logic [15:0] w_step;        // zero-extended step amount
    logic [15:0] w_full_res;    // 16-bit wrap-around result
    logic [6:0]  w_low7_res;    // 7-bit wrap-around result for refresh mode
    logic [15:0] w_func_res;    // selected F(AL, cy, dec, limit7)

    // The buses are read back in full, so when ctl_al_out is asserted the
    // latch sees its own RES drive: this is the feedback path used for
    // repeated increments (AL <= RES).
    assign w_bus_in = {db_hi_as, db_lo_as};

    // Address arithmetic: full 16-bit step, or low-7-bit step with the upper
    // nine bits passed through unchanged (refresh counter behaviour).
    always_comb begin
        w_step     = {15'd0, ctl_if.ctl_inc_cy};
        w_full_res = ctl_if.ctl_inc_dec ? (al_q - w_step) : (al_q + w_step);
        w_low7_res = ctl_if.ctl_inc_dec ? (al_q[6:0] - w_step[6:0])
                                        : (al_q[6:0] + w_step[6:0]);
        w_func_res = ctl_if.ctl_inc_limit7 ? {al_q[15:7], w_low7_res}
                                           : w_full_res;
    end

    // Next-state logic: latch from the bus, refresh RES one edge later using
    // the controls present on that later edge, track the pending flag.
    always_comb begin
        al_d       = al_q;
        res_d      = res_q;
        res_pend_d = res_pend_q;
        abus_oe_d  = ctl_if.ctl_bus_oe;

        // RES capture always uses the pre-edge AL, so back-to-back latches
        // make RES trail AL by one latch.
        if (res_pend_q) begin
            res_d      = w_func_res;
            res_pend_d = 1'b0;
        end

        // A latch on the same edge re-arms the pending flag.
        if (ctl_if.ctl_al_we) begin
            al_d       = w_bus_in;
            res_pend_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously so a pending update is
    // discarded by reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            al_q       <= 16'd0;
            res_q      <= 16'd0;
            res_pend_q <= 1'b0;
            abus_oe_q  <= 1'b0;
        end else begin
            al_q       <= al_d;
            res_q      <= res_d;
            res_pend_q <= res_pend_d;
            abus_oe_q  <= abus_oe_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional AL == 1 detector
    // ------------------------------------------------------------------------
`ifdef ADDR_ZERO_DETECT_EN
    logic addr_is_1_q, addr_is_1_d;

    // Flag follows the value being latched; it holds between latches.
    always_comb begin
        addr_is_1_d = addr_is_1_q;
        if (ctl_if.ctl_al_we) begin
            addr_is_1_d = (w_bus_in == c_ADDR_ONE);
        end
    end

    // Flag register, cleared with the rest of the state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            addr_is_1_q <= 1'b0;
        end else begin
            addr_is_1_q <= addr_is_1_d;
        end
    end

    assign ctl_if.address_is_1 = addr_is_1_q;
`else
    assign ctl_if.address_is_1 = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ctl_if.abus_oe  = abus_oe_q;
    assign ctl_if.res_pend = res_pend_q;

    // Bus drivers are gated by reset directly so the pins float for the whole
    // time reset is held, independent of the control inputs.
    assign db_hi_as = (ctl_if.ctl_al_out && nreset) ? res_q[15:8] : 8'hzz;
    assign db_lo_as = (ctl_if.ctl_al_out && nreset) ? res_q[7:0]  : 8'hzz;
    assign address  = (abus_oe_q && nreset)         ? al_q        : 16'hzzzz;

endmodule : addr_latch_incdec
`default_nettype wire
